dual_xor_rx: RTL and testbench

Receive-side counterpart of the dual-XOR cipher transmitter. Deserialises 8N1 UART frames from `rxd` and decrypts each byte by XOR with a keystream byte from two M-bit Galois LFSRs. Buffers the plaintext in a 4-entry FIFO and presents it on a valid/ready stream. Sits between the board UART pin and the FPGA-side consumer (LED/console logic) in the Arty-35T build.

---
 rtl/dual_xor_rx.sv | 243 ++++++++++++++++++++++++
 tb/tb_dual_xor_rx.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_xor_rx.sv
// dual_xor_rx: 8N1 UART receiver with dual-Galois-LFSR XOR decryption and a
// 4-entry plaintext FIFO on a valid/ready stream.
// Optional build macro: DUAL_XOR_RX_BYPASS_EN removes the keystream entirely
// and forwards received bytes to the FIFO unmodified.
module dual_xor_rx #(
   parameter int unsigned   M          = 32,
   parameter int unsigned   BIT_PERIOD = 868,
   parameter logic [M-1:0]  POLY       = M'(32'h8020_0003),
   parameter logic [M-1:0]  SEED_A     = M'(32'h1234_5678),
   parameter logic [M-1:0]  SEED_B     = M'(32'h0BAD_F00D)
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rxd,
   input  logic       resync,
   output logic [7:0] m_data,
   output logic       m_valid,
   input  logic       m_ready,
   output logic       frame_err,
   output logic       overrun
);

   localparam int unsigned CNT_W = $clog2(BIT_PERIOD + 1);
   localparam int unsigned DEPTH = 4;
   localparam int unsigned CNT_F = 3;
   localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(BIT_PERIOD / 2);
   localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(BIT_PERIOD);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_t;

   // synchroniser and edge-detect history
   logic rxd_meta_q, rxd_sync_q, rxd_prev_q;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       shift_q, shift_d;
   logic             tick_c;
   logic             complete_c;

   logic [7:0]       key_c;
   logic [7:0]       plain_c;
   logic             stop_ok_c;
   logic             full_c;
   logic             pop_c;
   logic             wr_c;
   logic [1:0]       wr_idx_c;

   logic [7:0]       mem_q [DEPTH];
   logic [7:0]       mem_d [DEPTH];
   logic [CNT_F-1:0] count_q, count_d;
   logic             valid_q, valid_d;
   logic             frame_err_q, frame_err_d;
   logic             overrun_q, overrun_d;

   // Two-flop synchroniser; reset low so a line held low at release cannot fake a start edge
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rxd_meta_q <= 1'b0;
         rxd_sync_q <= 1'b0;
         rxd_prev_q <= 1'b0;
      end else begin
         rxd_meta_q <= rxd;
         rxd_sync_q <= rxd_meta_q;
         rxd_prev_q <= rxd_sync_q;
      end
   end

   assign tick_c = (cnt_q == CNT_W'(1));

   // RX framing FSM: next state, bit timer, shift register, completion strobe
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bit_idx_d  = bit_idx_q;
      shift_d    = shift_q;
      complete_c = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (rxd_prev_q && !rxd_sync_q) begin
               state_d = S_START;
               cnt_d   = HALF_BIT;
            end
         end
         S_START: begin
            if (tick_c) begin
               if (rxd_sync_q) begin
                  state_d = S_IDLE;
               end else begin
                  state_d   = S_DATA;
                  cnt_d     = FULL_BIT;
                  bit_idx_d = 3'd0;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_DATA: begin
            if (tick_c) begin
               shift_d = {rxd_sync_q, shift_q[7:1]};
               cnt_d   = FULL_BIT;
               if (bit_idx_q == 3'd7) begin
                  state_d = S_STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_STOP: begin
            if (tick_c) begin
               complete_c = 1'b1;
               state_d    = rxd_sync_q ? S_IDLE : S_BREAK;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_BREAK: begin
            if (rxd_sync_q) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // FSM registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
      end
   end

`ifdef DUAL_XOR_RX_BYPASS_EN
   logic unused_resync;
   assign unused_resync = resync;
   assign key_c         = 8'h00;
`else
   // A zero seed would lock the LFSR, so it is replaced by all-ones
   localparam logic [M-1:0] SEED_A_EFF = (SEED_A == '0) ? '1 : SEED_A;
   localparam logic [M-1:0] SEED_B_EFF = (SEED_B == '0) ? '1 : SEED_B;

   logic [M-1:0] lfsr_a_q, lfsr_a_d;
   logic [M-1:0] lfsr_b_q, lfsr_b_d;

   function automatic logic [M-1:0] galois_step(input logic [M-1:0] s);
      return s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
   endfunction

   // Keystream update: resync reload takes priority over the per-frame advance
   always_comb begin
      lfsr_a_d = lfsr_a_q;
      lfsr_b_d = lfsr_b_q;
      if (resync) begin
         lfsr_a_d = SEED_A_EFF;
         lfsr_b_d = SEED_B_EFF;
      end else if (complete_c) begin
         lfsr_a_d = galois_step(lfsr_a_q);
         lfsr_b_d = galois_step(lfsr_b_q);
      end
   end

   // Keystream registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lfsr_a_q <= SEED_A_EFF;
         lfsr_b_q <= SEED_B_EFF;
      end else begin
         lfsr_a_q <= lfsr_a_d;
         lfsr_b_q <= lfsr_b_d;
      end
   end

   assign key_c = lfsr_a_q[7:0] ^ lfsr_b_q[7:0];
`endif

   assign plain_c   = shift_q ^ key_c;
   assign stop_ok_c = complete_c && rxd_sync_q;
   assign full_c    = (count_q == CNT_F'(DEPTH));
   assign pop_c     = valid_q && m_ready;
   assign wr_c      = stop_ok_c && (!full_c || pop_c);

   // Shift-style FIFO (head always in mem[0]) plus status pulses
   always_comb begin
      mem_d       = mem_q;
      count_d     = count_q;
      wr_idx_c    = count_q[1:0];
      frame_err_d = complete_c && !rxd_sync_q;
      overrun_d   = stop_ok_c && full_c && !pop_c;
      if (pop_c) begin
         for (int unsigned i = 0; i < DEPTH - 1; i++) begin
            mem_d[i] = mem_q[i+1];
         end
         count_d  = count_q - CNT_F'(1);
         wr_idx_c = 2'(count_q - CNT_F'(1));
      end
      if (wr_c) begin
         mem_d[wr_idx_c] = plain_c;
         count_d         = count_d + CNT_F'(1);
      end
      valid_d = (count_d != '0);
   end

   // FIFO and output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         count_q     <= '0;
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         mem_q       <= mem_d;
         count_q     <= count_d;
         valid_q     <= valid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   assign m_data    = mem_q[0];
   assign m_valid   = valid_q;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_dual_xor_rx.sv
// Scoreboard bench for dual_xor_rx at BIT_PERIOD=16 with default seeds.
module tb_dual_xor_rx;

   localparam int unsigned BP      = 16;
   localparam logic [31:0] TB_POLY = 32'h8020_0003;
   localparam logic [31:0] TB_SA   = 32'h1234_5678;
   localparam logic [31:0] TB_SB   = 32'h0BAD_F00D;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       rxd = 1'b1;
   logic       resync = 1'b0;
   logic       m_ready = 1'b0;
   logic [7:0] m_data;
   logic       m_valid;
   logic       frame_err;
   logic       overrun;

   int n_checks = 0;
   int n_errors = 0;
   int fe_cnt   = 0;
   int ov_cnt   = 0;
   logic [7:0]  exp_q[$];
   logic [7:0]  mon_exp;
   logic [31:0] ka, kb;

   always #5 clk = ~clk;

   dual_xor_rx #(
      .M(32), .BIT_PERIOD(BP), .POLY(TB_POLY), .SEED_A(TB_SA), .SEED_B(TB_SB)
   ) dut (
      .clk(clk), .rst(rst), .rxd(rxd), .resync(resync),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
      .frame_err(frame_err), .overrun(overrun)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every accepted output beat is compared against the queue head
   always @(negedge clk) begin
      if (rst && m_valid && m_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_output: got 0x%0h expected none", m_data);
         end else begin
            mon_exp = exp_q.pop_front();
            check("m_data", 32'(m_data), 32'(mon_exp));
         end
      end
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
   end

   function automatic logic [31:0] step(input logic [31:0] s);
      return s[0] ? ((s >> 1) ^ TB_POLY) : (s >> 1);
   endfunction

   task automatic model_reset();
      ka = TB_SA;
      kb = TB_SB;
   endtask

   task automatic next_key(output logic [7:0] k);
      k  = ka[7:0] ^ kb[7:0];
      ka = step(ka);
      kb = step(kb);
   endtask

   task automatic idle(input int n);
      rxd = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      rxd = b;
      repeat (BP) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit(stop);
      rxd = 1'b1;
   endtask

   task automatic send_exp(input logic [7:0] d);
      logic [7:0] k;
      next_key(k);
      exp_q.push_back(d ^ k);
      send_frame(d, 1'b1);
   endtask

   task automatic wait_drain(input string name);
      bit done = 1'b0;
      for (int i = 0; i < 400 && !done; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !m_valid) done = 1'b1;
      end
      check(name, 32'(done), 32'd1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] k;
      logic [7:0] head;
      int fe0, ov0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("rst_m_data", 32'(m_data), 32'h0);
      check("rst_m_valid", 32'(m_valid), 32'h0);
      check("rst_frame_err", 32'(frame_err), 32'h0);
      check("rst_overrun", 32'(overrun), 32'h0);
      rst = 1'b1;
      idle(5);

      // first frame: 0x5A with key 0x75 decrypts to 0x2F; m_valid latency
      exp_q.push_back(8'h2F);
      next_key(k);
      fork
         send_frame(8'h5A, 1'b1);
         begin
            repeat (153) @(posedge clk);
            @(negedge clk);
            check("valid_before_stop", 32'(m_valid), 32'h0);
            repeat (3) @(posedge clk);
            @(negedge clk);
            check("valid_after_stop", 32'(m_valid), 32'h1);
            check("head_first", 32'(m_data), 32'h2F);
         end
      join
      m_ready = 1'b1;
      wait_drain("drain_first");

      // five back-to-back frames into a stalled FIFO
      m_ready = 1'b0;
      fe0 = fe_cnt;
      ov0 = ov_cnt;
      next_key(k);
      exp_q.push_back(8'h39);       // 0x00 ^ key#2 (0x39)
      send_frame(8'h00, 1'b1);
      next_key(k);
      exp_q.push_back(8'h60);       // 0xFF ^ key#3 (0x9F)
      send_frame(8'hFF, 1'b1);
      send_exp(8'hA5);
      send_exp(8'h3C);
      next_key(k);
      send_frame(8'h77, 1'b1);
      idle(4);
      check("overrun_pulses", 32'(ov_cnt - ov0), 32'd1);
      check("fe_no_pulse_overrun", 32'(fe_cnt - fe0), 32'd0);
      check("full_valid", 32'(m_valid), 32'h1);
      head = exp_q[0];
      check("stalled_head", 32'(m_data), 32'(head));
      m_ready = 1'b1;
      wait_drain("drain_full");
      send_exp(8'hC3);
      wait_drain("drain_sixth");

      // stop bit low: frame error, no write, keystream still advances
      fe0 = fe_cnt;
      ov0 = ov_cnt;
      next_key(k);
      send_frame(8'h81, 1'b0);
      idle(2 * BP);
      check("frame_err_pulses", 32'(fe_cnt - fe0), 32'd1);
      check("ov_no_pulse_ferr", 32'(ov_cnt - ov0), 32'd0);
      send_exp(8'h42);
      wait_drain("drain_after_ferr");

      // short low glitch on an idle line: false start
      fe0 = fe_cnt;
      ov0 = ov_cnt;
      rxd = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      idle(3 * BP);
      check("glitch_fe", 32'(fe_cnt - fe0), 32'd0);
      check("glitch_ov", 32'(ov_cnt - ov0), 32'd0);
      check("glitch_valid", 32'(m_valid), 32'h0);
      send_exp(8'h99);
      wait_drain("drain_after_glitch");

      // resync after three frames restarts the keystream
      send_exp(8'h10);
      send_exp(8'h20);
      send_exp(8'h30);
      wait_drain("drain_three");
      resync = 1'b1;
      @(posedge clk);
      #1;
      resync = 1'b0;
      model_reset();
      idle(4);
      exp_q.push_back(8'h2F);
      next_key(k);
      send_frame(8'h5A, 1'b1);
      wait_drain("drain_resync");

      // resync on the completion cycle: this byte old key, next byte key #1
      idle(4);
      next_key(k);
      exp_q.push_back(8'h13 ^ k);
      model_reset();
      fork
         send_frame(8'h13, 1'b1);
         begin
            repeat (154) @(posedge clk);
            #1;
            resync = 1'b1;
            @(posedge clk);
            #1;
            resync = 1'b0;
         end
      join
      idle(4);
      exp_q.push_back(8'h2F);
      next_key(k);
      send_frame(8'h5A, 1'b1);
      wait_drain("drain_resync_edge");

      // reset in the middle of a frame clears everything immediately
      m_ready = 1'b0;
      send_exp(8'h11);
      idle(2);
      check("pre_reset_valid", 32'(m_valid), 32'h1);
      fork
         send_frame(8'hF0, 1'b1);
         begin
            repeat (60) @(posedge clk);
            #1;
            rst = 1'b0;
            #1;
            check("mid_rst_valid", 32'(m_valid), 32'h0);
            check("mid_rst_data", 32'(m_data), 32'h0);
            check("mid_rst_fe", 32'(frame_err), 32'h0);
            check("mid_rst_ov", 32'(overrun), 32'h0);
         end
      join
      exp_q.delete();
      model_reset();
      fe0 = fe_cnt;
      ov0 = ov_cnt;
      idle(5);
      rst = 1'b1;
      idle(5);
      check("post_rst_fe", 32'(fe_cnt - fe0), 32'd0);
      check("post_rst_ov", 32'(ov_cnt - ov0), 32'd0);
      m_ready = 1'b1;
      exp_q.push_back(8'h2F);
      next_key(k);
      send_frame(8'h5A, 1'b1);
      wait_drain("drain_after_rst");

      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
